parse_act_cfg_ctrl: RTL and testbench

- Controller for the parser action table RAM. The RAM is dual-port: port A is write-only, port B is read-only, and reads have 1-cycle latency.
- Assembles 32-bit configuration beats from the control path into full action entries and commits each complete entry to port A in a single write cycle.
- Sequences parser lookups on port B with a fixed response latency.
- Forwards a write's data to a lookup of the same address in the same cycle, so the parser never sees a stale entry.

---
 rtl/parse_act_cfg_ctrl_pkg.sv | 13 +
 rtl/parse_act_cfg_ctrl_if.sv | 34 +++
 rtl/parse_act_cfg_ctrl_lkup_pipe.sv | 48 ++++
 rtl/parse_act_cfg_ctrl.sv | 126 ++++++++++++
 tb/tb_parse_act_cfg_ctrl.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/parse_act_cfg_ctrl_pkg.sv
// Shared types and constants for the parser action table controller.
package parse_act_cfg_ctrl_pkg;

    localparam int CFG_WORD_BITS = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2,
        COMMIT  = 2'd3
    } cfg_state_e;

endpackage

// File: rtl/parse_act_cfg_ctrl_if.sv
// Config-beat and lookup handshake bundle between the control path/parser
// (master) and the action table controller (slave).
interface parse_act_cfg_ctrl_if #(
    parameter int ADDR_BITS = 5,
    parameter int DATA_BITS = 160
) ();
    import parse_act_cfg_ctrl_pkg::*;

    logic                     cfg_wvalid;
    logic                     cfg_wready;
    logic [CFG_WORD_BITS-1:0] cfg_wdata;
    logic [ADDR_BITS-1:0]     cfg_waddr;
    logic                     cfg_wlast;
    logic                     cfg_err;
    logic                     lkup_req_valid;
    logic [ADDR_BITS-1:0]     lkup_req_addr;
    logic                     lkup_rsp_valid;
    logic [DATA_BITS-1:0]     lkup_rsp_data;

    modport master (
        output cfg_wvalid, cfg_wdata, cfg_waddr, cfg_wlast,
        input  cfg_wready, cfg_err,
        output lkup_req_valid, lkup_req_addr,
        input  lkup_rsp_valid, lkup_rsp_data
    );

    modport slave (
        input  cfg_wvalid, cfg_wdata, cfg_waddr, cfg_wlast,
        output cfg_wready, cfg_err,
        input  lkup_req_valid, lkup_req_addr,
        output lkup_rsp_valid, lkup_rsp_data
    );

endinterface

// File: rtl/parse_act_cfg_ctrl_lkup_pipe.sv
// Two-stage lookup response pipeline: stage 1 tracks the request issued to
// the RAM, stage 2 registers the RAM output (or the same-cycle commit data).
module parse_act_cfg_ctrl_lkup_pipe #(
    parameter int DATA_BITS = 160
) (
    input  logic                 clk,
    input  logic                 aresetn,
    input  logic                 req_valid,
    input  logic                 byp_hit,
    input  logic [DATA_BITS-1:0] byp_data,
    input  logic [DATA_BITS-1:0] ram_doutb,
    output logic                 rsp_valid,
    output logic [DATA_BITS-1:0] rsp_data
);

    logic                 v1;
    logic                 hit1;
    logic [DATA_BITS-1:0] byp_q;

    // Stage 1: remember an issued read and capture commit data if it collides
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            v1    <= 1'b0;
            hit1  <= 1'b0;
            byp_q <= '0;
        end else begin
            v1   <= req_valid;
            hit1 <= byp_hit;
            if (byp_hit) begin
                byp_q <= byp_data;
            end
        end
    end

    // Stage 2: register the response; data holds while no response is due
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= v1;
            if (v1) begin
                rsp_data <= hit1 ? byp_q : ram_doutb;
            end
        end
    end

endmodule

// File: rtl/parse_act_cfg_ctrl.sv
// Parser action table controller: assembles config beats into entries,
// commits them on RAM port A, and serves lookups on port B with bypass.
module parse_act_cfg_ctrl #(
    parameter int ADDR_BITS = 5,
    parameter int DATA_BITS = 160
) (
    input  logic                 clk,
    input  logic                 aresetn,
    parse_act_cfg_ctrl_if.slave  bus,
    output logic [ADDR_BITS-1:0] ram_addra,
    output logic [DATA_BITS-1:0] ram_dina,
    output logic                 ram_ena,
    output logic                 ram_wea,
    output logic [ADDR_BITS-1:0] ram_addrb,
    output logic                 ram_enb,
    input  logic [DATA_BITS-1:0] ram_doutb
);
    import parse_act_cfg_ctrl_pkg::*;

    localparam int BEATS    = DATA_BITS / CFG_WORD_BITS;
    localparam int CNT_BITS = $clog2(BEATS + 1);

    cfg_state_e           state, state_nxt;
    logic [CNT_BITS-1:0]  count, count_nxt;
    logic [ADDR_BITS-1:0] addr_q, addr_nxt;
    logic [DATA_BITS-1:0] asm_q, asm_nxt;
    logic                 commit;
    logic                 byp_hit;

    // Beat assembler state, latched address and entry register
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state  <= IDLE;
            count  <= '0;
            addr_q <= '0;
            asm_q  <= '0;
        end else begin
            state  <= state_nxt;
            count  <= count_nxt;
            addr_q <= addr_nxt;
            asm_q  <= asm_nxt;
        end
    end

    // Beat acceptance, entry length checking and commit sequencing
    always_comb begin
        state_nxt      = state;
        count_nxt      = count;
        addr_nxt       = addr_q;
        asm_nxt        = asm_q;
        bus.cfg_wready = 1'b1;
        bus.cfg_err    = 1'b0;
        commit         = 1'b0;
        case (state)
            IDLE: begin
                if (bus.cfg_wvalid) begin
                    addr_nxt = bus.cfg_waddr;
                    asm_nxt  = '0;
                    asm_nxt[DATA_BITS-1 -: CFG_WORD_BITS] = bus.cfg_wdata;
                    count_nxt = CNT_BITS'(1);
                    if (BEATS == 1) begin
                        state_nxt = bus.cfg_wlast ? COMMIT : DRAIN;
                    end else if (bus.cfg_wlast) begin
                        bus.cfg_err = 1'b1;
                        count_nxt   = '0;
                    end else begin
                        state_nxt = COLLECT;
                    end
                end
            end
            COLLECT: begin
                if (bus.cfg_wvalid) begin
                    asm_nxt[DATA_BITS-1-CFG_WORD_BITS*int'(count) -: CFG_WORD_BITS] = bus.cfg_wdata;
                    count_nxt = count + CNT_BITS'(1);
                    if (int'(count) == BEATS - 1) begin
                        state_nxt = bus.cfg_wlast ? COMMIT : DRAIN;
                        count_nxt = '0;
                    end else if (bus.cfg_wlast) begin
                        bus.cfg_err = 1'b1;
                        state_nxt   = IDLE;
                        count_nxt   = '0;
                    end
                end
            end
            DRAIN: begin
                if (bus.cfg_wvalid && bus.cfg_wlast) begin
                    bus.cfg_err = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            COMMIT: begin
                bus.cfg_wready = 1'b0;
                commit         = 1'b1;
                state_nxt      = IDLE;
                count_nxt      = '0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign ram_ena   = commit;
    assign ram_wea   = commit;
    assign ram_addra = addr_q;
    assign ram_dina  = asm_q;

    assign ram_addrb = bus.lkup_req_addr;
    assign ram_enb   = bus.lkup_req_valid;

    // RAM port B is read-first, so a read colliding with the commit must
    // take the commit data instead of the RAM output.
    assign byp_hit = commit && bus.lkup_req_valid && (bus.lkup_req_addr == addr_q);

    parse_act_cfg_ctrl_lkup_pipe #(
        .DATA_BITS (DATA_BITS)
    ) u_lkup_pipe (
        .clk       (clk),
        .aresetn   (aresetn),
        .req_valid (bus.lkup_req_valid),
        .byp_hit   (byp_hit),
        .byp_data  (asm_q),
        .ram_doutb (ram_doutb),
        .rsp_valid (bus.lkup_rsp_valid),
        .rsp_data  (bus.lkup_rsp_data)
    );

endmodule

// File: tb/tb_parse_act_cfg_ctrl.sv
// Self-checking bench: transaction-level expectations recorded by the driver,
// a commit-history lookup model, and a per-cycle compare process.
module tb_parse_act_cfg_ctrl;

    localparam int AB    = 5;
    localparam int DB    = 160;
    localparam int BEATS = DB / 32;

    logic          clk = 1'b0;
    logic          aresetn = 1'b0;
    logic [AB-1:0] ram_addra;
    logic [DB-1:0] ram_dina;
    logic          ram_ena;
    logic          ram_wea;
    logic [AB-1:0] ram_addrb;
    logic          ram_enb;
    logic [DB-1:0] ram_doutb = '0;

    parse_act_cfg_ctrl_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) bus ();

    parse_act_cfg_ctrl #(.ADDR_BITS(AB), .DATA_BITS(DB)) dut (
        .clk       (clk),
        .aresetn   (aresetn),
        .bus       (bus),
        .ram_addra (ram_addra),
        .ram_dina  (ram_dina),
        .ram_ena   (ram_ena),
        .ram_wea   (ram_wea),
        .ram_addrb (ram_addrb),
        .ram_enb   (ram_enb),
        .ram_doutb (ram_doutb)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DB-1:0] init_val(input int a);
        logic [31:0] a32;
        a32 = 32'(a);
        return {32'hA000_0000 | a32, 32'hB100_0000 | a32, 32'hC200_0000 | a32,
                32'hD300_0000 | a32, 32'hE400_0000 | a32};
    endfunction

    // Read-first dual-port RAM environment
    logic [DB-1:0] mem [32];
    initial for (int i = 0; i < 32; i++) mem[i] = init_val(i);
    always @(posedge clk) begin
        if (ram_enb) ram_doutb <= mem[ram_addrb];
        if (ram_ena && ram_wea) mem[ram_addra] <= ram_dina;
    end

    task automatic chk(input string name, input logic [DB-1:0] act, input logic [DB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Expectations keyed by cycle index
    bit            err_at  [int];
    bit            wr_at   [int];
    logic [AB-1:0] wr_addr [int];
    logic [DB-1:0] wr_data [int];
    logic [AB-1:0] lk_at   [int];
    int            hist_cyc [$];
    logic [AB-1:0] hist_addr [$];
    logic [DB-1:0] hist_data [$];
    logic [DB-1:0] last_rsp = '0;

    // Entry content seen by a lookup issued in cycle t: latest commit at or before t
    function automatic logic [DB-1:0] ref_lookup(input logic [AB-1:0] a, input int t);
        logic [DB-1:0] r;
        r = init_val(int'(a));
        foreach (hist_cyc[i]) if (hist_cyc[i] <= t && hist_addr[i] == a) r = hist_data[i];
        return r;
    endfunction

    // Per-cycle compare against the model
    logic [DB-1:0] exp_d;
    bit            exp_w;
    always @(negedge clk) begin
        if (!aresetn) begin
            chk("rst_wready", DB'(bus.cfg_wready), DB'(1));
            chk("rst_rsp_valid", DB'(bus.lkup_rsp_valid), DB'(0));
            chk("rst_rsp_data", bus.lkup_rsp_data, '0);
            chk("rst_wea", DB'(ram_wea), DB'(0));
            chk("rst_err", DB'(bus.cfg_err), DB'(0));
            lk_at.delete();
            last_rsp = '0;
        end else begin
            exp_w = wr_at.exists(cyc);
            chk("wready", DB'(bus.cfg_wready), DB'(!exp_w));
            chk("ram_wea", DB'(ram_wea), DB'(exp_w));
            chk("ram_ena", DB'(ram_ena), DB'(exp_w));
            if (exp_w) begin
                chk("ram_addra", DB'(ram_addra), DB'(wr_addr[cyc]));
                chk("ram_dina", ram_dina, wr_data[cyc]);
            end
            chk("cfg_err", DB'(bus.cfg_err), DB'(err_at.exists(cyc)));
            chk("ram_enb", DB'(ram_enb), DB'(bus.lkup_req_valid));
            if (bus.lkup_req_valid) chk("ram_addrb", DB'(ram_addrb), DB'(bus.lkup_req_addr));
            if (lk_at.exists(cyc - 2)) begin
                exp_d = ref_lookup(lk_at[cyc - 2], cyc - 2);
                chk("rsp_valid", DB'(bus.lkup_rsp_valid), DB'(1));
                chk("rsp_data", bus.lkup_rsp_data, exp_d);
                last_rsp = exp_d;
            end else begin
                chk("rsp_valid_idle", DB'(bus.lkup_rsp_valid), DB'(0));
                chk("rsp_data_hold", bus.lkup_rsp_data, last_rsp);
            end
            if (bus.lkup_req_valid) lk_at[cyc] = bus.lkup_req_addr;
        end
    end

    // ---------------- driver ----------------
    bit          lk_rand = 1'b0;
    logic [31:0] wbuf [8];

    task automatic drive_cycle(input bit v, input logic [31:0] d, input logic [AB-1:0] a,
                               input bit l, input bit lv, input logic [AB-1:0] la);
        @(posedge clk);
        #1;
        bus.cfg_wvalid     = v;
        bus.cfg_wdata      = d;
        bus.cfg_waddr      = a;
        bus.cfg_wlast      = l;
        bus.lkup_req_valid = lv;
        bus.lkup_req_addr  = la;
    endtask

    task automatic pick_lk(output bit lv, output logic [AB-1:0] la);
        lv = lk_rand ? ($urandom_range(0, 2) != 0) : 1'b0;
        la = ($urandom_range(0, 3) == 0) ? AB'(7) : AB'($urandom_range(0, 31));
    endtask

    task automatic idle(input int n);
        bit lv;
        logic [AB-1:0] la;
        for (int i = 0; i < n; i++) begin
            pick_lk(lv, la);
            drive_cycle(1'b0, $urandom, AB'($urandom), 1'($urandom), lv, la);
        end
    endtask

    task automatic load_words(input logic [DB-1:0] v);
        for (int k = 0; k < BEATS; k++) wbuf[k] = v[DB-1-32*k -: 32];
    endtask

    // Sends nb beats (wlast on the final one); records commit or error expectations.
    task automatic send_entry(input logic [AB-1:0] addr, input int nb, input bit gaps,
                              input bit lk_tail, input logic [AB-1:0] tail_addr);
        bit            lv;
        logic [AB-1:0] la;
        int            lastc;
        logic [DB-1:0] ent;
        for (int k = 0; k < nb; k++) begin
            if (gaps) idle($urandom_range(0, 2));
            pick_lk(lv, la);
            if (lk_tail && k == nb - 1) begin lv = 1'b1; la = tail_addr; end
            drive_cycle(1'b1, wbuf[k], (k == 0) ? addr : AB'($urandom), k == nb - 1, lv, la);
        end
        lastc = cyc;
        if (nb == BEATS) begin
            ent = '0;
            for (int k = 0; k < BEATS; k++) ent[DB-1-32*k -: 32] = wbuf[k];
            wr_at[lastc + 1]   = 1'b1;
            wr_addr[lastc + 1] = addr;
            wr_data[lastc + 1] = ent;
            hist_cyc.push_back(lastc + 1);
            hist_addr.push_back(addr);
            hist_data.push_back(ent);
            // Commit cycle: any beat offered now must be ignored
            pick_lk(lv, la);
            if (lk_tail) begin lv = 1'b1; la = tail_addr; end
            drive_cycle(1'($urandom), $urandom, AB'($urandom), 1'($urandom), lv, la);
        end else begin
            err_at[lastc] = 1'b1;
        end
    endtask

    localparam logic [DB-1:0] P = 160'h01234567_89ABCDEF_DEADBEEF_CAFEF00D_13579BDF;
    localparam logic [DB-1:0] Q = 160'h11111111_22222222_33333333_44444444_55555555;
    localparam logic [DB-1:0] R = 160'h0BADC0DE_600DF00D_FEEDFACE_8BADF00D_D15EA5E0;

    logic [DB-1:0] got [$];
    int            nb;

    initial begin
        bus.cfg_wvalid = 1'b0; bus.cfg_wdata = '0; bus.cfg_waddr = '0; bus.cfg_wlast = 1'b0;
        bus.lkup_req_valid = 1'b0; bus.lkup_req_addr = '0;
        repeat (3) @(posedge clk);
        #1 aresetn = 1'b1;
        idle(2);

        // Entry P to address 7
        load_words(P);
        send_entry(AB'(7), BEATS, 1'b0, 1'b0, '0);
        @(negedge clk);
        chk("P_commit_wea", DB'(ram_wea), DB'(1));
        chk("P_commit_addr", DB'(ram_addra), DB'(7));
        chk("P_commit_data", ram_dina, P);
        chk("P_commit_wready", DB'(bus.cfg_wready), DB'(0));
        idle(2);
        drive_cycle(1'b0, '0, '0, 1'b0, 1'b1, AB'(7));
        idle(2);
        @(negedge clk);
        chk("P_lkup_valid", DB'(bus.lkup_rsp_valid), DB'(1));
        chk("P_lkup_data", bus.lkup_rsp_data, P);

        // Q to 7 with lookups one cycle before and during the commit
        load_words(Q);
        send_entry(AB'(7), BEATS, 1'b0, 1'b1, AB'(7));
        idle(1);
        @(negedge clk);
        chk("pre_commit_lkup", bus.lkup_rsp_data, P);
        idle(1);
        @(negedge clk);
        chk("bypass_lkup", bus.lkup_rsp_data, Q);

        // Short entry (wlast on beat 2), then a good one
        load_words(R);
        send_entry(AB'(3), 3, 1'b0, 1'b0, '0);
        @(negedge clk);
        chk("short_err", DB'(bus.cfg_err), DB'(1));
        idle(1);
        send_entry(AB'(3), BEATS, 1'b0, 1'b0, '0);
        idle(1);

        // Long entry: 7 beats, wlast on beat 6
        for (int k = 0; k < 8; k++) wbuf[k] = $urandom;
        send_entry(AB'(12), 7, 1'b0, 1'b0, '0);
        @(negedge clk);
        chk("long_err", DB'(bus.cfg_err), DB'(1));
        idle(2);

        // Reset on beat 3 with two lookups in flight
        load_words(Q);
        drive_cycle(1'b1, wbuf[0], AB'(9), 1'b0, 1'b0, '0);
        drive_cycle(1'b1, wbuf[1], '0, 1'b0, 1'b1, AB'(7));
        drive_cycle(1'b1, wbuf[2], '0, 1'b0, 1'b1, AB'(3));
        drive_cycle(1'b1, wbuf[3], '0, 1'b0, 1'b0, '0);
        aresetn = 1'b0;
        drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, '0);
        drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, '0);
        aresetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, '0);
            @(negedge clk);
            chk("post_rst_rsp_valid", DB'(bus.lkup_rsp_valid), DB'(0));
            chk("post_rst_wready", DB'(bus.cfg_wready), DB'(1));
            chk("post_rst_wea", DB'(ram_wea), DB'(0));
        end

        // 32 back-to-back lookups
        for (int a = 0; a < 35; a++) begin
            drive_cycle(1'b0, '0, '0, 1'b0, a < 32, AB'(a));
            @(negedge clk);
            if (bus.lkup_rsp_valid) got.push_back(bus.lkup_rsp_data);
        end
        chk("b2b_count", DB'(got.size()), DB'(32));
        if (got.size() == 32) begin
            chk("b2b_addr0", got[0], init_val(0));
            chk("b2b_addr3", got[3], R);
            chk("b2b_addr7", got[7], Q);
            chk("b2b_addr31", got[31], init_val(31));
        end

        // Randomized entries with concurrent random lookups
        lk_rand = 1'b1;
        for (int e = 0; e < 60; e++) begin
            for (int k = 0; k < 8; k++) wbuf[k] = $urandom;
            case ($urandom_range(0, 9))
                6:       nb = 1;
                7:       nb = $urandom_range(2, BEATS - 1);
                8, 9:    nb = $urandom_range(BEATS + 1, BEATS + 3);
                default: nb = BEATS;
            endcase
            send_entry(AB'($urandom), nb, 1'($urandom), ($urandom_range(0, 3) == 0), AB'(7));
        end
        lk_rand = 1'b0;
        idle(4);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
